// File: rtl/seq_word_comp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_word_comp_ctrl
// Description : Compares two NBYTES-wide unsigned operands by time-sharing one
//               external 8-bit cascadable magnitude-comparator slice, MSB
//               byte first. Reports a one-hot gt/eq/lt result with a
//               busy/done handshake and flags non-one-hot slice verdicts.
// Options     : SEQ_COMP_EARLY_EXIT_EN - when defined, the scan stops on the
//               first unequal byte (data-dependent latency). When undefined,
//               all NBYTES bytes are always scanned (constant latency).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_word_comp_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   a_in,
   input  logic [8*NBYTES-1:0]   b_in,
   output logic                  busy,
   output logic                  done,
   output logic                  gt,
   output logic                  eq,
   output logic                  lt,
   output logic                  err,
   output logic [7:0]            cmp_a,
   output logic [7:0]            cmp_b,
   output logic                  cmp_l_in,
   output logic                  cmp_e_in,
   output logic                  cmp_g_in,
   input  logic                  cmp_l,
   input  logic                  cmp_e,
   input  logic                  cmp_g
);

   localparam int              IDXW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q;
   logic [8*NBYTES-1:0]   a_q;
   logic [8*NBYTES-1:0]   b_q;
   logic [IDXW-1:0]       idx_q;
   logic                  rec_gt_q;
   logic                  rec_lt_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  gt_q;
   logic                  eq_q;
   logic                  lt_q;
   logic                  err_q;

   logic                  verdict_ok;
   logic                  unequal;
   logic                  last_byte;
   logic                  scan_exit;
   logic                  rec_gt_d;
   logic                  rec_lt_d;

   // The cascade inputs force the slice to decide purely on its own byte pair.
   assign cmp_l_in = 1'b0;
   assign cmp_e_in = 1'b1;
   assign cmp_g_in = 1'b0;

   // The slice always sees the currently indexed byte of the latched operands.
   assign cmp_a = a_q[8*idx_q +: 8];
   assign cmp_b = b_q[8*idx_q +: 8];

   assign verdict_ok = ({cmp_l, cmp_e, cmp_g} == 3'b100) ||
                       ({cmp_l, cmp_e, cmp_g} == 3'b010) ||
                       ({cmp_l, cmp_e, cmp_g} == 3'b001);
   assign unequal    = cmp_g | cmp_l;
   assign last_byte  = (idx_q == '0);

   // The first unequal byte wins; later bytes never overwrite the record.
   assign rec_gt_d = rec_gt_q | (~rec_gt_q & ~rec_lt_q & cmp_g);
   assign rec_lt_d = rec_lt_q | (~rec_gt_q & ~rec_lt_q & cmp_l);

`ifdef SEQ_COMP_EARLY_EXIT_EN
   assign scan_exit = last_byte | unequal;
`else
   assign scan_exit = last_byte;
`endif

   assign busy = busy_q;
   assign done = done_q;
   assign gt   = gt_q;
   assign eq   = eq_q;
   assign lt   = lt_q;
   assign err  = err_q;

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= LAST_IDX;
         rec_gt_q <= 1'b0;
         rec_lt_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q      <= a_in;
                  b_q      <= b_in;
                  idx_q    <= LAST_IDX;
                  rec_gt_q <= 1'b0;
                  rec_lt_q <= 1'b0;
                  gt_q     <= 1'b0;
                  eq_q     <= 1'b0;
                  lt_q     <= 1'b0;
                  err_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end else begin
                  state_q  <= S_IDLE;
               end
            end
            S_RUN: begin
               if (!verdict_ok) begin
                  // A broken slice verdict aborts at once with a neutral result.
                  err_q   <= 1'b1;
                  eq_q    <= 1'b1;
                  gt_q    <= 1'b0;
                  lt_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  rec_gt_q <= rec_gt_d;
                  rec_lt_q <= rec_lt_d;
                  if (scan_exit) begin
                     gt_q    <= rec_gt_d;
                     lt_q    <= rec_lt_d;
                     eq_q    <= ~(rec_gt_d | rec_lt_d);
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     idx_q   <= idx_q - 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_word_comp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_word_comp_ctrl
// Description : Self-checking bench for seq_word_comp_ctrl with a behavioural
//               8-bit comparator slice, vector table and expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_word_comp_ctrl;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          busy, done, gt, eq, lt, err;
   logic [7:0]    cmp_a, cmp_b;
   logic          cmp_l_in, cmp_e_in, cmp_g_in;
   logic          cmp_l, cmp_e, cmp_g;
   logic          force_bad = 1'b0;

   int checks   = 0;
   int failures = 0;
   int mid_cyc  = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         gt;
      logic         eq;
      logic         lt;
   } vec_t;

   typedef struct {
      logic gt;
      logic eq;
      logic lt;
      logic err;
      int   lat;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] seq_a[$];
   logic [7:0] seq_b[$];

   always #5 clk = ~clk;

   seq_word_comp_ctrl #(.NBYTES(NBYTES)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .gt       (gt),
      .eq       (eq),
      .lt       (lt),
      .err      (err),
      .cmp_a    (cmp_a),
      .cmp_b    (cmp_b),
      .cmp_l_in (cmp_l_in),
      .cmp_e_in (cmp_e_in),
      .cmp_g_in (cmp_g_in),
      .cmp_l    (cmp_l),
      .cmp_e    (cmp_e),
      .cmp_g    (cmp_g)
   );

   // Behavioural comparator slice; force_bad injects an illegal G=E=1 verdict.
   always_comb begin
      cmp_l = 1'b0;
      cmp_e = 1'b0;
      cmp_g = 1'b0;
      if (force_bad) begin
         cmp_g = 1'b1;
         cmp_e = 1'b1;
      end else begin
         cmp_l = (cmp_a < cmp_b);
         cmp_e = (cmp_a == cmp_b);
         cmp_g = (cmp_a > cmp_b);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Cycles from the accepting edge to the done cycle.
   function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_COMP_EARLY_EXIT_EN
      for (int k = NBYTES - 1; k >= 0; k--)
         if (a[8*k +: 8] != b[8*k +: 8]) return NBYTES - k + 1;
`endif
      return NBYTES + 1;
   endfunction

   task automatic check_idle_zero(input string name);
      check({name, "_busy"}, busy, 0);
      check({name, "_done"}, done, 0);
      check({name, "_res"},  {gt, eq, lt}, 0);
      check({name, "_err"},  err, 0);
      check({name, "_cmpa"}, cmp_a, 0);
      check({name, "_cmpb"}, cmp_b, 0);
   endtask

   // Called at a falling edge; returns at the falling edge of the done cycle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic egt, input logic eeq, input logic elt,
                         input logic eerr, input int elat, input string name);
      exp_t e;
      e.gt = egt; e.eq = eeq; e.lt = elt; e.err = eerr; e.lat = elat;
      sb.push_back(e);
      seq_a.delete();
      seq_b.delete();
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            check({name, "_busy_run"}, busy, 1);
            check({name, "_cleared"}, {gt, eq, lt, err}, 0);
         end
         if (done) begin
            start = 1'b0;
            e = sb.pop_front();
            check({name, "_result"}, {gt, eq, lt}, {e.gt, e.eq, e.lt});
            check({name, "_err"},    err, e.err);
            check({name, "_latency"}, cyc, e.lat);
            check({name, "_busy_done"}, busy, 0);
            return;
         end
         seq_a.push_back(cmp_a);
         seq_b.push_back(cmp_b);
         if (cyc == mid_cyc) begin
            start = 1'b1;
            a_in  = ~a;
            b_in  = a;
         end else begin
            start = 1'b0;
         end
      end
      void'(sb.pop_front());
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
   endtask

   task automatic check_seq(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
      check({name, "_seqlen"}, seq_a.size(), NBYTES);
      for (int k = 0; k < NBYTES && k < seq_a.size(); k++) begin
         check({name, "_seqa"}, seq_a[k], a[8*(NBYTES-1-k) +: 8]);
         check({name, "_seqb"}, seq_b[k], b[8*(NBYTES-1-k) +: 8]);
      end
   endtask

   vec_t vecs[8];

   initial begin
      logic [W-1:0] ra, rb;
      int           sel;

      vecs[0] = '{32'h4F123456, 32'h78000000, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{32'hCFCFCFCF, 32'hCFCFCFCF, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{32'hCF0000FF, 32'hCF0000FE, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_zero("reset");
      check("casc_in", {cmp_l_in, cmp_e_in, cmp_g_in}, 3'b010);
      rst = 1'b0;
      @(negedge clk);
      check_idle_zero("idle");

      // Table: odd entries are issued back-to-back in the previous done cycle.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) @(negedge clk);
         run_op(vecs[i].a, vecs[i].b, vecs[i].gt, vecs[i].eq, vecs[i].lt, 1'b0,
                exp_lat(vecs[i].a, vecs[i].b), $sformatf("vec%0d", i));
      end

      // Random operands, often sharing upper bytes.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sel = $urandom_range(0, 2);
         ra  = $urandom;
         if (sel == 0)      rb = ra;
         else if (sel == 1) rb = ra ^ (32'h000000FF << (8 * $urandom_range(0, NBYTES - 1)));
         else               rb = $urandom;
         run_op(ra, rb, ra > rb, ra == rb, ra < rb, 1'b0, exp_lat(ra, rb),
                $sformatf("rnd%0d", i));
      end

      // Byte presentation order.
      @(negedge clk);
      run_op(32'hCFCFCFCF, 32'hCFCFCFCF, 1'b0, 1'b1, 1'b0, 1'b0, NBYTES + 1, "eqseq");
      check_seq("eqseq", 32'hCFCFCFCF, 32'hCFCFCFCF);
      @(negedge clk);
      run_op(32'hCF0000FF, 32'hCF0000FE, 1'b1, 1'b0, 1'b0, 1'b0, NBYTES + 1, "gtseq");
      check_seq("gtseq", 32'hCF0000FF, 32'hCF0000FE);

      // start during RUN must be ignored.
      @(negedge clk);
      mid_cyc = 2;
      run_op(32'h11223344, 32'h11223345, 1'b0, 1'b0, 1'b1, 1'b0, NBYTES + 1, "midstart");
      mid_cyc = 0;

      // Reset in the second RUN cycle discards the operation.
      @(negedge clk);
      a_in  = 32'h12345678;
      b_in  = 32'h12345600;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle_zero("midrst");
      rst = 1'b0;
      @(negedge clk);
      run_op(32'h4F123456, 32'h78000000, 1'b0, 1'b0, 1'b1, 1'b0,
             exp_lat(32'h4F123456, 32'h78000000), "afterrst");

      // Illegal slice verdict on the first byte.
      @(negedge clk);
      force_bad = 1'b1;
      run_op(32'hCF0000FF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 2, "errop");
      force_bad = 1'b0;
      @(negedge clk);
      check("err_held", err, 1);
      run_op(32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b1, 1'b0,
             exp_lat(32'h00000002, 32'h00000003), "errclr");

      @(negedge clk);
      check("final_idle_busy", busy, 0);
      check("final_done_low", done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_word_comp_ctrl.md
# seq_word_comp_ctrl

Sequential controller that compares two NBYTES-wide unsigned operands by time-sharing one external 8-bit cascadable magnitude-comparator slice (inputs a, b, L, E, G; outputs L, E, G). It latches both operands on a start pulse and presents one byte pair per cycle, most significant byte first. It collects the slice verdict and reports a one-hot gt/eq/lt result with a busy/done handshake. It sits between the requesting logic and the shared comparator slice, so wide compares need no extra comparator hardware.

## Interface
- NBYTES, 4, operand width in bytes (≥1); counter width = clog2(NBYTES), minimum 1.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE or DONE.
- a_in  in  8*NBYTES  operand A, sampled on the accepting edge.
- b_in  in  8*NBYTES  operand B, sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse in DONE.
- gt / eq / lt  out  1 each  result, one-hot after done, held until the next accepted start.
- err  out  1  slice returned a non-one-hot verdict during the last operation.
- cmp_a / cmp_b  out  8 each  byte pair to the slice (registered operand bytes).
- cmp_l_in / cmp_e_in / cmp_g_in  out  1 each  cascade inputs to the slice, constant 0/1/0.
- cmp_l / cmp_e / cmp_g  in  1 each  combinational slice verdict for the current byte pair.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: busy=0, done=0, gt=0, eq=0, lt=0, err=0, cmp_a=0, cmp_b=0; byte index=NBYTES-1; operand registers=0.
- IDLE/DONE with start=1: latch a_in/b_in, set idx=NBYTES-1, clear gt/eq/lt/err, go to RUN.
- DONE with start=0: go to IDLE. Results stay held.
- RUN: cmp_a/cmp_b = byte idx of the latched operands; sample the slice verdict at each edge.
  - Verdict not exactly one-hot: set err=1, set eq=1, go to DONE. This happens in both builds.
  - Verdict G or L with no prior unequal byte: record gt or lt (sticky; a later byte cannot overwrite it).
  - Verdict E: no record.
  - Exit: see Configuration. When idx=0 is evaluated, go to DONE. If nothing was recorded, set eq=1.
- start in RUN is ignored; there is no queueing.
- Operands are unsigned. Byte NBYTES-1 (bits [8*NBYTES-1:8*NBYTES-8]) is presented first.

## Timing
- Accepting edge E0. busy=1 from cycle E0+1. RUN byte k (k=0..m-1) is presented in cycle E0+1+k.
- done=1 and busy=0 in cycle E0+1+m. gt/eq/lt are valid in that same cycle.
- m = NBYTES for a full scan; m = (index of first unequal byte from MSB)+1 on early exit.
- Back-to-back: start asserted during the done cycle is accepted, and the next RUN starts the cycle after.
- rst asserted in any state: at that edge, all outputs take reset values and the state becomes IDLE. A partial result is discarded.

## Configuration
- SEQ_COMP_EARLY_EXIT_EN defined: RUN moves to DONE on the first unequal byte, so latency depends on the data.
- Not defined: RUN always scans all NBYTES bytes and the result is the first unequal byte (sticky). Latency is constant at NBYTES+1 cycles from the accepting edge to done, for timing-uniform use.
- The err path exits immediately in both builds.

## Test plan
- Reset: hold rst 2 cycles → busy=0, done=0, gt=eq=lt=0, err=0, cmp_a=cmp_b=0; state IDLE.
- a=0x4F123456, b=0x78000000, start → lt=1. With SEQ_COMP_EARLY_EXIT_EN, done comes 2 cycles after the accepting edge. Without it, done comes 5 cycles after, and lt is still 1 despite the later bytes 0x12>0x00.
- a=0xCFCFCFCF, b=0xCFCFCFCF → eq=1, done 5 cycles after start in both builds; cmp_a sequence CF,CF,CF,CF.
- a=0xCF0000FF, b=0xCF0000FE → gt=1 after 4 RUN cycles; cmp_a/cmp_b sequence CF/CF, 00/00, 00/00, FF/FE.
- start pulsed again mid-RUN → ignored, and the original result is returned. rst at the 2nd RUN cycle → next cycle busy=0, all outputs 0, IDLE. A following start works normally.
- Slice model forced to G=E=1 on the first byte → err=1, eq=1, done 2 cycles after start; err clears on the next accepted start.
